// File: rtl/rvs_xrf_rt_receiver_pkg.sv
// Shared types and constants for the RVS side of the XRF retire channel.
package rvs_xrf_rt_receiver_pkg;

  localparam int unsigned NUM_RT_XRF = 4;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REGIDX_W   = 5;

  typedef struct packed {
    logic [XLEN-1:0]     rt_data;
    logic [REGIDX_W-1:0] rt_index;
  } RT_XRF_t;

endpackage

// File: rtl/rvs_xrf_rt_receiver_if.sv
// XRF retire channel from the vector backend: per-lane valid/data, per-lane ready back.
interface rvs_xrf_rt_receiver_if #(
  parameter int unsigned NUM_RT_XRF = rvs_xrf_rt_receiver_pkg::NUM_RT_XRF
);

  logic [NUM_RT_XRF-1:0]           rt_xrf_valid_rvv2rvs;
  rvs_xrf_rt_receiver_pkg::RT_XRF_t rt_xrf_rvv2rvs [NUM_RT_XRF];
  logic [NUM_RT_XRF-1:0]           rt_xrf_ready_rvs2rvv;

  modport master (
    output rt_xrf_valid_rvv2rvs,
    output rt_xrf_rvv2rvs,
    input  rt_xrf_ready_rvs2rvv
  );

  modport slave (
    input  rt_xrf_valid_rvv2rvs,
    input  rt_xrf_rvv2rvs,
    output rt_xrf_ready_rvs2rvv
  );

endinterface

// File: rtl/rvs_xrf_rt_receiver_fifo.sv
// In-order FIFO: up to N entries pushed per cycle (lanes 0..push_n-1), one popped per cycle.
module rvs_multi_push_fifo #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1,
  localparam int unsigned NW   = $clog2(N + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NW-1:0]                    push_n_i,
  input  rvs_xrf_rt_receiver_pkg::RT_XRF_t push_data_i [N],
  input  logic                             pop_i,
  output rvs_xrf_rt_receiver_pkg::RT_XRF_t head_o,
  output logic [CW-1:0]                    count_o
);

  import rvs_xrf_rt_receiver_pkg::*;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  RT_XRF_t       mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push_n_i);
      rd_ptr_q <= rd_ptr_q + PW'(pop_i);
      count_q  <= count_q + CW'(push_n_i) - CW'(pop_i);
    end
  end

  // Storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (NW'(i) < push_n_i) begin
        mem_q[wr_ptr_q + PW'(i)] <= push_data_i[i];
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rvs_xrf_rt_receiver.sv
// Scalar-side XRF retire receiver: credit-style ready, in-order buffering, x0 drop, RF write handshake.
module rvs_xrf_rt_receiver #(
  parameter int unsigned NUM_RT_XRF = rvs_xrf_rt_receiver_pkg::NUM_RT_XRF,
  parameter int unsigned XLEN       = rvs_xrf_rt_receiver_pkg::XLEN,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned CW        = $clog2(DEPTH) + 1,
  localparam int unsigned NW        = $clog2(NUM_RT_XRF + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rvs_xrf_rt_receiver_if.slave  rt_if,
  output logic                  xrf_wr_en,
  output logic [4:0]            xrf_wr_addr,
  output logic [XLEN-1:0]       xrf_wr_data,
  input  logic                  xrf_wr_ready,
  output logic [CW-1:0]         fifo_count,
  output logic                  busy
);

  import rvs_xrf_rt_receiver_pkg::*;

  logic                  rst_n_q;
  logic [NUM_RT_XRF-1:0] ready;
  logic [NUM_RT_XRF-1:0] valid;
  logic [NW-1:0]         push_n;
  logic                  pop;
  logic                  head_vld;
  logic                  head_is_x0;
  RT_XRF_t               head;
  logic [CW-1:0]         count;

  always_ff @(posedge clk) begin
    if (!rst_n) rst_n_q <= 1'b0;
    else        rst_n_q <= 1'b1;
  end

  assign valid = rt_if.rt_xrf_valid_rvv2rvs;

  // Ready depends only on registered occupancy, so a same-cycle pop earns no credit.
  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < NUM_RT_XRF; i++) begin
      ready[i] = rst_n_q && ((int'(DEPTH) - int'(count)) >= (int'(i) + 1));
    end
  end

  always_comb begin
    push_n = '0;
    for (int unsigned i = 0; i < NUM_RT_XRF; i++) begin
      if (valid[i] && ready[i]) push_n = push_n + NW'(1);
    end
  end

  assign rt_if.rt_xrf_ready_rvs2rvv = ready;

  rvs_multi_push_fifo #(
    .N     (NUM_RT_XRF),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_n_i    (push_n),
    .push_data_i (rt_if.rt_xrf_rvv2rvs),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign head_vld   = rst_n && (count != '0);
  assign head_is_x0 = (head.rt_index == '0);
  assign pop        = head_vld && (head_is_x0 || xrf_wr_ready);

  assign xrf_wr_en   = head_vld && !head_is_x0;
  assign xrf_wr_addr = xrf_wr_en ? head.rt_index : '0;
  assign xrf_wr_data = xrf_wr_en ? head.rt_data  : '0;
  assign fifo_count  = count;
  assign busy        = (count != '0);

  a_valid_prefix: assert property (@(posedge clk) disable iff (!rst_n)
    ((valid & (valid + NUM_RT_XRF'(1))) == '0));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (count <= CW'(DEPTH)));

  a_no_push_unready: assert property (@(posedge clk) disable iff (!rst_n)
    (ready == '0) |-> (push_n == '0));

  a_wr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (xrf_wr_en && !xrf_wr_ready) |=> ($stable(xrf_wr_addr) && $stable(xrf_wr_data)));

endmodule
